// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: per-cycle pipeline probe recorder with trigger, post-trigger window and circular readback
module pipe_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CH*DATA_W-1:0]         probe_bus,
  input  logic                             probe_valid,
  input  logic                             cpu_halt,
  input  logic                             arm,
  input  logic [1:0]                       trig_mode,
  input  logic [CH_W-1:0]                  trig_ch,
  input  logic [DATA_W-1:0]                trig_value,
  input  logic [AW-1:0]                    post_trig,
  input  logic                             rd_req,
  input  logic [AW-1:0]                    rd_index,
  output logic                             rd_valid,
  output logic [CNT_W+NUM_CH*DATA_W-1:0]   rd_data,
  output logic                             rd_err,
  output logic [AW:0]                      entries,
  output logic                             wrapped,
  output logic [CNT_W-1:0]                 cycle_count,
  output logic [1:0]                       state,
  output logic                             triggered
);
  localparam int ENT_W = CNT_W + NUM_CH*DATA_W;
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, DONE = 2'b11} state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, post_cnt_q, post_cnt_d, rd_addr;
  logic [AW:0]        entries_q, entries_d;
  logic               wrapped_q, wrapped_d, triggered_q, triggered_d;
  logic               rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
  logic [ENT_W-1:0]   rd_data_q, rd_data_d;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]  sel_ch;
  logic               match, halt_hit, hit, capture;
  always_comb begin
    sel_ch = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (CH_W'(k) == trig_ch) sel_ch = probe_bus[k*DATA_W +: DATA_W];
  end
  assign match    = (state_q == ARMED) & probe_valid & (sel_ch == trig_value);
  assign halt_hit = cpu_halt & ((trig_mode == 2'b00) | (trig_mode == 2'b10));
  assign hit      = (state_q == ARMED) & (halt_hit | (match & ((trig_mode == 2'b01) | (trig_mode == 2'b10))));
  assign capture  = ~arm & probe_valid & ((state_q == ARMED) | (state_q == POST));
  always_comb begin
    cycle_count_d = cycle_count_q + CNT_W'(1);
    state_d       = state_q;
    post_cnt_d    = post_cnt_q;
    wr_ptr_d      = capture ? wr_ptr_q + AW'(1) : wr_ptr_q;
    entries_d     = (capture && entries_q != (AW+1)'(DEPTH)) ? entries_q + (AW+1)'(1) : entries_q;
    wrapped_d     = wrapped_q | (capture & (wr_ptr_q == AW'(DEPTH-1)));
    triggered_d   = triggered_q | hit;
    // arm restarts the capture and wins over any hit or capture in the same cycle
    if (arm) begin
      state_d     = ARMED;
      wr_ptr_d    = '0;
      entries_d   = '0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
    end else if (hit) begin
      state_d    = (post_trig == '0 || halt_hit) ? DONE : POST;
      post_cnt_d = post_trig;
    end else if (state_q == POST && cpu_halt) begin
      state_d = DONE;
    end else if (state_q == POST && capture) begin
      post_cnt_d = post_cnt_q - AW'(1);
      state_d    = (post_cnt_q == AW'(1)) ? DONE : POST;
    end
  end
  assign rd_addr = (wrapped_q ? wr_ptr_q : AW'(0)) + rd_index;
  always_comb begin
    rd_valid_d = rd_req;
    rd_err_d   = rd_req ? ({1'b0, rd_index} >= entries_q) : rd_err_q;
    rd_data_d  = rd_req ? (rd_err_d ? '0 : mem[rd_addr]) : rd_data_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cycle_count_q <= '0;
      wr_ptr_q      <= '0;
      post_cnt_q    <= '0;
      entries_q     <= '0;
      wrapped_q     <= 1'b0;
      triggered_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_err_q      <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      wr_ptr_q      <= wr_ptr_d;
      post_cnt_q    <= post_cnt_d;
      entries_q     <= entries_d;
      wrapped_q     <= wrapped_d;
      triggered_q   <= triggered_d;
      rd_valid_q    <= rd_valid_d;
      rd_err_q      <= rd_err_d;
      rd_data_q     <= rd_data_d;
    end
  end
  always_ff @(posedge clock)
    if (reset && capture) mem[wr_ptr_q] <= {cycle_count_q, probe_bus};
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_err      = rd_err_q;
  assign entries     = entries_q;
  assign wrapped     = wrapped_q;
  assign cycle_count = cycle_count_q;
  assign state       = state_q;
  assign triggered   = triggered_q;
endmodule
